// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial ripple adder, one sum bit per clock, LSB first
//
// Purpose:
//   Adds two WIDTH-bit unsigned operands plus a carry-in by shifting them
//   through a single full adder, one bit per cycle. The result is
//   A + B + cin modulo 2^WIDTH, and the overflow bit appears on cout.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..32)
//
// Ports:
//   clk    single clock, rising edge
//   rst    asynchronous active-high reset
//   start  request an addition; sampled only in IDLE or DONE
//   a, b   operands, captured on an accepted start
//   cin    carry-in, captured on an accepted start
//   sum    registered result (shows partial values while busy)
//   cout   registered carry-out of the MSB, held until the next DONE
//   busy   high while the adder is shifting
//   done   one-cycle pulse when sum/cout are final
//   ovf    (only with SERIAL_ADDER_OVF_EN) signed overflow: carry into MSB
//          XOR carry out of MSB, held like sum
//
// Build option:
//   SERIAL_ADDER_OVF_EN  adds the ovf output and its logic
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             done,
    output logic             ovf
`else
    output logic             done
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    logic w_sum_bit;
    logic w_carry_nxt;
    logic w_last;

    assign w_sum_bit   = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry_nxt = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    // Counter runs 0..WIDTH-1 and the FSM leaves SHIFT on the last value,
    // so the counter never wraps inside one operation.
    assign w_last      = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                S_SHIFT: begin
                    // start is deliberately not looked at here
                    r_sum   <= {w_sum_bit, r_sum[WIDTH-1:1]};
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_carry_nxt;
                    if (w_last) begin
                        r_cout  <= w_carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
                        // r_carry is the carry into the MSB on the last bit
                        r_ovf   <= r_carry ^ w_carry_nxt;
`endif
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign busy = r_busy;
    assign done = r_done;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8)
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       busy;
    logic       done;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
`endif

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
`ifdef SERIAL_ADDER_OVF_EN
        .done  (done),
        .ovf   (ovf)
`else
        .done  (done)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one rising edge; returns at the
    // falling edge inside the first SHIFT cycle.
    task automatic launch(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        @(negedge clk);
        a     = ta;
        b     = tb;
        cin   = tc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 8'hA5;
        b     = 8'h5A;
        cin   = 1'b1;
    endtask

    // Counts falling edges until done; the start edge T is followed by
    // done after edge T+8, i.e. on the 8th falling edge after launch.
    task automatic wait_done(input string tag, input int exp_lat,
                             input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, ovf, eo);
`else
        if (eo === 1'bx) check({tag, "_eo"}, 1'b0, 1'b1);
`endif
    endtask

    initial begin
        int dcnt;
        int dfirst;

        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sum", sum, 8'h00);
        check("rst_cout", cout, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;

        // 0x0F + 0x01 + 0
        launch(8'h0F, 8'h01, 1'b0);
        check("op1_busy", busy, 1'b1);
        wait_done("op1", 8, 8'h10, 1'b0, 1'b0);
        @(negedge clk);
        check("op1_pulse", done, 1'b0);
        repeat (3) @(negedge clk);
        check("op1_hold_sum", sum, 8'h10);
        check("op1_hold_busy", busy, 1'b0);

        // 0xFF + 0x01 wraps with carry-out
        launch(8'hFF, 8'h01, 1'b0);
        wait_done("op2", 8, 8'h00, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("op2_hold_cout", cout, 1'b1);

        // carry-in alone
        launch(8'h00, 8'h00, 1'b1);
        wait_done("op3", 8, 8'h01, 1'b0, 1'b0);

        // signed overflow cases
        launch(8'h7F, 8'h01, 1'b0);
        wait_done("op4", 8, 8'h80, 1'b0, 1'b1);

        // start held high mid-SHIFT with other operands must be ignored
        launch(8'h12, 8'h34, 1'b0);
        dcnt   = 0;
        dfirst = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcnt++;
                if (dfirst == 0) dfirst = k;
            end
            if (k == 1) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
            end
            if (k == 4) start = 1'b0;
        end
        check("ign_done_cnt", dcnt, 1);
        check("ign_done_at", dfirst, 8);
        check("ign_sum", sum, 8'h46);
        check("ign_cout", cout, 1'b0);

        launch(8'h80, 8'h80, 1'b0);
        wait_done("op5", 8, 8'h00, 1'b1, 1'b1);

        // reset in the 4th SHIFT cycle: 0xAA+0x55 has no carries, so after
        // three shifts the top three result bits are 1.
        launch(8'hAA, 8'h55, 1'b0);
        repeat (3) @(negedge clk);
        check("mid_sum", sum, 8'hE0);
        check("mid_busy", busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("arst_sum", sum, 8'h00);
        check("arst_cout", cout, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        #1 rst = 1'b0;
        dcnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        check("arst_no_done", dcnt, 0);
        launch(8'h05, 8'h03, 1'b0);
        wait_done("op6", 8, 8'h08, 1'b0, 1'b0);

        // back-to-back: start presented during DONE
        launch(8'h20, 8'h22, 1'b0);
        wait_done("b2b1", 8, 8'h42, 1'b0, 1'b0);
        a     = 8'h01;
        b     = 8'h02;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", busy, 1'b1);
        check("b2b_done_low", done, 1'b0);
        // one edge already elapsed, so 9 cycles from the first done in total
        wait_done("b2b2", 8, 8'h03, 1'b0, 1'b0);
        @(negedge clk);
        check("b2b_pulse", done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
